// File: rtl/dsp_mac_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : dsp_mac_pkg                                                |
// | Purpose  : shared constants, output range helper and parameter        |
// |            legality check for the dsp_mac_acc slice                   |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package dsp_mac_pkg;

   // Accumulate direction carried alongside each beat
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Inclusive output bounds, held in 64 bits so any supported width fits
   typedef struct packed {
      logic [63:0] min;
      logic [63:0] max;
   } range_t;

   // Signed: [-2^(w-1), 2^(w-1)-1]; unsigned: [0, 2^w-1]
   function automatic range_t out_range(input int w, input bit is_signed);
      range_t r;
      if (is_signed) begin
         r.max = (64'd1 << (w - 1)) - 64'd1;
         r.min = ~r.max;
      end else begin
         r.min = '0;
         r.max = (64'd1 << w) - 64'd1;
      end
      return r;
   endfunction

   // The accumulator must hold a full product plus one growth bit, the
   // output may not be wider than the accumulator, and the widened
   // rounding path must fit the 64-bit range helper.
   function automatic bit cfg_ok(input int a_w, input int b_w,
                                 input int acc_w, input int o_w);
      return (acc_w >= a_w + b_w + 1) && (o_w <= acc_w) && (acc_w <= 62);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_mac_acc_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface: dsp_mac_acc_if                                             |
// | Purpose  : beat input and result output bundle of dsp_mac_acc         |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
interface dsp_mac_acc_if #(
   parameter int A_W   = 12,
   parameter int B_W   = 12,
   parameter int ACC_W = 32,
   parameter int O_W   = 16,
   parameter int SH_W  = 5
);
   logic             ce;
   logic             in_valid;
   logic             in_first;
   logic             in_last;
   logic             in_sub;
   logic [A_W-1:0]   a;
   logic [B_W-1:0]   b;
   logic [ACC_W-1:0] c;
   logic [SH_W-1:0]  shift;
   logic             out_valid;
   logic [O_W-1:0]   out_data;
   logic             out_ovfl;
   logic             acc_busy;

   // Sample source side
   modport master (
      output ce, in_valid, in_first, in_last, in_sub, a, b, c, shift,
      input  out_valid, out_data, out_ovfl, acc_busy
   );

   // MAC side
   modport slave (
      input  ce, in_valid, in_first, in_last, in_sub, a, b, c, shift,
      output out_valid, out_data, out_ovfl, acc_busy
   );
endinterface
`default_nettype wire

// File: rtl/dsp_mac_round_sat.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dsp_mac_round_sat                                          |
// | Purpose  : round-half-up right shift and narrowing of the accumulator;|
// |            clamps to the output range when DSP_MAC_SAT_EN is defined, |
// |            otherwise wraps to the low output bits                     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module dsp_mac_round_sat
   import dsp_mac_pkg::*;
#(
   parameter int ACC_W  = 32,
   parameter int O_W    = 16,
   parameter int SH_W   = 5,
   parameter int SIGNED = 1
) (
   input  wire logic [ACC_W-1:0] i_acc,
   input  wire logic [SH_W-1:0]  i_shift,
   output logic      [O_W-1:0]   o_data,
   output logic                  o_ovfl
);
   // One extra bit so the rounding increment can never wrap
   localparam int R_W = ACC_W + 1;

   logic [R_W-1:0] w_ext;
   logic [R_W-1:0] w_rnd;
   logic [R_W-1:0] w_sum;
   logic [R_W-1:0] w_r;

   // Widen, add half an LSB of the shifted result, then shift
   always_comb begin
      w_ext = (SIGNED != 0) ? {i_acc[ACC_W-1], i_acc} : {1'b0, i_acc};
      w_rnd = '0;
      if (i_shift != '0)
         w_rnd = R_W'(1) << (i_shift - SH_W'(1));
      w_sum = w_ext + w_rnd;
      if (SIGNED != 0)
         w_r = $signed(w_sum) >>> i_shift;
      else
         w_r = w_sum >> i_shift;
   end

`ifdef DSP_MAC_SAT_EN
   localparam range_t c_rng = out_range(O_W, SIGNED != 0);
   // Bounds one bit wider than w_r so a single signed compare serves both modes
   localparam logic signed [R_W:0] c_max = c_rng.max[R_W:0];
   localparam logic signed [R_W:0] c_min = c_rng.min[R_W:0];

   logic signed [R_W:0] w_rs;

   // Clamp the shifted value into the output range and flag it
   always_comb begin
      w_rs   = {(SIGNED != 0) & w_r[R_W-1], w_r};
      o_data = w_r[O_W-1:0];
      o_ovfl = 1'b0;
      if (w_rs > c_max) begin
         o_data = c_max[O_W-1:0];
         o_ovfl = 1'b1;
      end else if (w_rs < c_min) begin
         o_data = c_min[O_W-1:0];
         o_ovfl = 1'b1;
      end
   end
`else
   logic w_unused_hi;

   // Plain wrap-around narrowing; the discarded high bits are intentional
   assign o_data      = w_r[O_W-1:0];
   assign o_ovfl      = 1'b0;
   assign w_unused_hi = ^w_r[R_W-1:O_W];
`endif

endmodule
`default_nettype wire

// File: rtl/dsp_mac_acc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dsp_mac_acc                                                |
// | Purpose  : 4-stage pipelined framed multiply-accumulate with rounding |
// |            right shift; output saturation when DSP_MAC_SAT_EN is      |
// |            defined                                                    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module dsp_mac_acc
   import dsp_mac_pkg::*;
#(
   parameter int A_W    = 12,
   parameter int B_W    = 12,
   parameter int ACC_W  = 32,
   parameter int O_W    = 16,
   parameter int SH_W   = 5,
   parameter int SIGNED = 1
) (
   input wire logic     CLK,
   input wire logic     a_RST,
   dsp_mac_acc_if.slave bus
);
   localparam int P_W = A_W + B_W;

   if (!cfg_ok(A_W, B_W, ACC_W, O_W)) begin : g_cfg_bad
      $error("dsp_mac_acc: illegal width parameters");
   end

   // S1 input register
   logic             r_s1_valid, r_s1_first, r_s1_last, r_s1_sub;
   logic [A_W-1:0]   r_s1_a;
   logic [B_W-1:0]   r_s1_b;
   logic [ACC_W-1:0] r_s1_c;
   logic [SH_W-1:0]  r_s1_shift;
   // S2 product register
   logic             r_s2_valid, r_s2_first, r_s2_last, r_s2_sub;
   logic [P_W-1:0]   r_s2_prod;
   logic [ACC_W-1:0] r_s2_c;
   logic [SH_W-1:0]  r_s2_shift;
   // S3 accumulator
   logic             r_s3_valid, r_s3_last, r_acc_busy;
   logic [ACC_W-1:0] r_acc;
   logic [SH_W-1:0]  r_s3_shift;
   // S4 output
   logic             r_out_valid, r_out_ovfl;
   logic [O_W-1:0]   r_out_data;

   logic [P_W-1:0]   w_prod;
   logic [ACC_W-1:0] w_prod_ext;
   logic [ACC_W-1:0] w_base;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [O_W-1:0]   w_rs_data;
   logic             w_rs_ovfl;

   // Capture the beat; frame markers only count on valid beats
   always_ff @(posedge CLK or posedge a_RST) begin
      if (a_RST) begin
         r_s1_valid <= 1'b0;  r_s1_first <= 1'b0;  r_s1_last <= 1'b0;
         r_s1_sub   <= 1'b0;  r_s1_a     <= '0;    r_s1_b    <= '0;
         r_s1_c     <= '0;    r_s1_shift <= '0;
      end else if (bus.ce) begin
         r_s1_valid <= bus.in_valid;
         r_s1_first <= bus.in_valid & bus.in_first;
         r_s1_last  <= bus.in_valid & bus.in_last;
         r_s1_sub   <= bus.in_sub;
         r_s1_a     <= bus.a;
         r_s1_b     <= bus.b;
         r_s1_c     <= bus.c;
         r_s1_shift <= bus.shift;
      end
   end

   if (SIGNED != 0) begin : g_prod_signed
      assign w_prod     = $signed(r_s1_a) * $signed(r_s1_b);
      assign w_prod_ext = ACC_W'($signed(r_s2_prod));
   end else begin : g_prod_unsigned
      assign w_prod     = r_s1_a * r_s1_b;
      assign w_prod_ext = ACC_W'(r_s2_prod);
   end

   // Register the product with its beat controls
   always_ff @(posedge CLK or posedge a_RST) begin
      if (a_RST) begin
         r_s2_valid <= 1'b0;  r_s2_first <= 1'b0;  r_s2_last  <= 1'b0;
         r_s2_sub   <= 1'b0;  r_s2_prod  <= '0;    r_s2_c     <= '0;
         r_s2_shift <= '0;
      end else if (bus.ce) begin
         r_s2_valid <= r_s1_valid;
         r_s2_first <= r_s1_first;
         r_s2_last  <= r_s1_last;
         r_s2_sub   <= r_s1_sub;
         r_s2_prod  <= w_prod;
         r_s2_c     <= r_s1_c;
         r_s2_shift <= r_s1_shift;
      end
   end

   // A first beat restarts from the preload, any other beat builds on acc
   always_comb begin
      w_base    = r_s2_first ? r_s2_c : r_acc;
      w_acc_nxt = (r_s2_sub == OP_SUB) ? (w_base - w_prod_ext)
                                       : (w_base + w_prod_ext);
   end

   // Accumulate valid beats and track whether a frame is open
   always_ff @(posedge CLK or posedge a_RST) begin
      if (a_RST) begin
         r_s3_valid <= 1'b0;  r_s3_last  <= 1'b0;  r_s3_shift <= '0;
         r_acc      <= '0;    r_acc_busy <= 1'b0;
      end else if (bus.ce) begin
         r_s3_valid <= r_s2_valid;
         r_s3_last  <= r_s2_last;
         r_s3_shift <= r_s2_shift;
         if (r_s2_valid) begin
            r_acc <= w_acc_nxt;
            if (r_s2_last)
               r_acc_busy <= 1'b0;
            else if (r_s2_first)
               r_acc_busy <= 1'b1;
         end
      end
   end

   dsp_mac_round_sat #(
      .ACC_W  (ACC_W),
      .O_W    (O_W),
      .SH_W   (SH_W),
      .SIGNED (SIGNED)
   ) u_round_sat (
      .i_acc   (r_acc),
      .i_shift (r_s3_shift),
      .o_data  (w_rs_data),
      .o_ovfl  (w_rs_ovfl)
   );

   // Emit a one-cycle result pulse when a closing beat leaves S3
   always_ff @(posedge CLK or posedge a_RST) begin
      if (a_RST) begin
         r_out_valid <= 1'b0;  r_out_data <= '0;  r_out_ovfl <= 1'b0;
      end else if (bus.ce) begin
         r_out_valid <= r_s3_valid & r_s3_last;
         if (r_s3_valid & r_s3_last) begin
            r_out_data <= w_rs_data;
            r_out_ovfl <= w_rs_ovfl;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ovfl  = r_out_ovfl;
   assign bus.acc_busy  = r_acc_busy;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_acc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_dsp_mac_acc                                             |
// | Purpose  : directed self-checking bench for dsp_mac_acc (SIGNED=1);   |
// |            expectations follow DSP_MAC_SAT_EN when it is defined      |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_dsp_mac_acc;
   localparam int A_W   = 12;
   localparam int B_W   = 12;
   localparam int ACC_W = 32;
   localparam int O_W   = 16;
   localparam int SH_W  = 5;

   logic CLK = 1'b0;
   logic a_RST;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         edge_no;
   int         res_cnt;
   int         res_edge;
   logic [15:0] res_data;
   logic        res_ovfl;

   always #5 CLK = ~CLK;

   dsp_mac_acc_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .O_W(O_W), .SH_W(SH_W)) bus ();

   dsp_mac_acc #(
      .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .O_W(O_W), .SH_W(SH_W), .SIGNED(1)
   ) u_dut (
      .CLK   (CLK),
      .a_RST (a_RST),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] d16(input int v);
      return {16'h0, v[15:0]};
   endfunction

   // One clock; record any result delivered on a ce-high edge
   task automatic step();
      logic ce_was;
      ce_was = bus.ce;
      @(posedge CLK);
      #1;
      edge_no++;
      if (ce_was && bus.out_valid) begin
         res_cnt++;
         res_data = bus.out_data;
         res_ovfl = bus.out_ovfl;
         res_edge = edge_no;
      end
   endtask

   task automatic beat(input bit f, input bit l, input bit s,
                       input int av, input int bv, input int cv, input int sh);
      bus.in_valid = 1'b1;
      bus.in_first = f;
      bus.in_last  = l;
      bus.in_sub   = s;
      bus.a        = A_W'(av);
      bus.b        = B_W'(bv);
      bus.c        = ACC_W'(cv);
      bus.shift    = SH_W'(sh);
      step();
   endtask

   task automatic bubble(input int n);
      repeat (n) begin
         bus.in_valid = 1'b0;
         bus.in_first = 1'b0;
         bus.in_last  = 1'b0;
         step();
      end
   endtask

   task automatic start_test();
      res_cnt  = 0;
      res_edge = 0;
      edge_no  = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ce = 1'b1;  bus.in_valid = 1'b0;  bus.in_first = 1'b0;  bus.in_last = 1'b0;
      bus.in_sub = 1'b0;  bus.a = '0;  bus.b = '0;  bus.c = '0;  bus.shift = '0;
      res_data = '0;  res_ovfl = 1'b0;
      a_RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_data",  d16(int'(bus.out_data)), 32'd0);
      check_eq("rst_ovfl",  32'(bus.out_ovfl), 32'd0);
      check_eq("rst_busy",  32'(bus.acc_busy), 32'd0);
      a_RST = 1'b0;
      bubble(2);

      // Single-term beat: 10 + (-3*5) = -5, four-cycle latency
      start_test();
      beat(1, 1, 0, -3, 5, 10, 0);
      bubble(2);
      check_eq("t1_early", 32'(res_cnt), 32'd0);
      bubble(1);
      check_eq("t1_valid", 32'(bus.out_valid), 32'd1);
      check_eq("t1_edge", 32'(res_edge), 32'd4);
      check_eq("t1_data", d16(int'(res_data)), d16(-5));
      check_eq("t1_busy", 32'(bus.acc_busy), 32'd0);
      bubble(1);
      check_eq("t1_pulse", 32'(bus.out_valid), 32'd0);
      bubble(2);
      check_eq("t1_count", 32'(res_cnt), 32'd1);

      // Four-beat frame: (4+9+16+25+2)>>2 = 14
      start_test();
      beat(1, 0, 0, 2, 2, 0, 0);
      beat(0, 0, 0, 3, 3, 0, 0);
      check_eq("t2_busy_e2", 32'(bus.acc_busy), 32'd0);
      beat(0, 0, 0, 4, 4, 0, 0);
      check_eq("t2_busy_e3", 32'(bus.acc_busy), 32'd1);
      beat(0, 1, 0, 5, 5, 0, 2);
      bubble(1);
      check_eq("t2_busy_e5", 32'(bus.acc_busy), 32'd1);
      bubble(1);
      check_eq("t2_busy_e6", 32'(bus.acc_busy), 32'd0);
      bubble(4);
      check_eq("t2_count", 32'(res_cnt), 32'd1);
      check_eq("t2_edge", 32'(res_edge), 32'd7);
      check_eq("t2_data", d16(int'(res_data)), d16(14));
      check_eq("t2_ovfl", 32'(res_ovfl), 32'd0);

      // Subtract beat: 1 - 49 + 1 = -47
      start_test();
      beat(1, 0, 0, 1, 1, 0, 0);
      beat(0, 0, 1, 7, 7, 0, 0);
      beat(0, 1, 0, 1, 1, 0, 0);
      bubble(6);
      check_eq("t3_count", 32'(res_cnt), 32'd1);
      check_eq("t3_data", d16(int'(res_data)), d16(-47));

      // Positive overflow: 4 * 2047*2047 = 16760836
      start_test();
      beat(1, 0, 0, 2047, 2047, 0, 0);
      beat(0, 0, 0, 2047, 2047, 0, 0);
      beat(0, 0, 0, 2047, 2047, 0, 0);
      beat(0, 1, 0, 2047, 2047, 0, 0);
      bubble(6);
      check_eq("t4_count", 32'(res_cnt), 32'd1);
`ifdef DSP_MAC_SAT_EN
      check_eq("t4_data", d16(int'(res_data)), 32'h7FFF);
      check_eq("t4_ovfl", 32'(res_ovfl), 32'd1);
`else
      check_eq("t4_data", d16(int'(res_data)), 32'hC004);
      check_eq("t4_ovfl", 32'(res_ovfl), 32'd0);
`endif

      // Negative overflow: -2048*2047 = -4192256
      start_test();
      beat(1, 1, 0, -2048, 2047, 0, 0);
      bubble(6);
`ifdef DSP_MAC_SAT_EN
      check_eq("t5_data", d16(int'(res_data)), 32'h8000);
      check_eq("t5_ovfl", 32'(res_ovfl), 32'd1);
`else
      check_eq("t5_data", d16(int'(res_data)), 32'h0800);
      check_eq("t5_ovfl", 32'(res_ovfl), 32'd0);
`endif

      // Three-cycle ce stall mid-frame; beats offered while stalled are ignored
      start_test();
      beat(1, 0, 0, 2, 2, 0, 0);
      beat(0, 0, 0, 3, 3, 0, 0);
      bus.ce = 1'b0;
      beat(0, 0, 0, 9, 9, 0, 0);
      beat(1, 1, 0, 9, 9, 0, 0);
      beat(0, 0, 0, 9, 9, 0, 0);
      bus.ce = 1'b1;
      beat(0, 0, 0, 4, 4, 0, 0);
      beat(0, 1, 0, 5, 5, 0, 2);
      bubble(6);
      check_eq("t6_count", 32'(res_cnt), 32'd1);
      check_eq("t6_edge", 32'(res_edge), 32'd10);
      check_eq("t6_data", d16(int'(res_data)), d16(14));

      // Bubbles between beats
      start_test();
      beat(1, 0, 0, 2, 2, 0, 0);
      bubble(1);
      beat(0, 0, 0, 3, 3, 0, 0);
      bubble(2);
      beat(0, 0, 0, 4, 4, 0, 0);
      bubble(1);
      beat(0, 1, 0, 5, 5, 0, 2);
      bubble(6);
      check_eq("t7_count", 32'(res_cnt), 32'd1);
      check_eq("t7_data", d16(int'(res_data)), d16(14));

      // First while busy restarts: 5 + 4 + 1 = 10
      start_test();
      beat(1, 0, 0, 10, 10, 0, 0);
      beat(1, 0, 0, 2, 2, 5, 0);
      beat(0, 1, 0, 1, 1, 0, 0);
      bubble(6);
      check_eq("t8_count", 32'(res_cnt), 32'd1);
      check_eq("t8_data", d16(int'(res_data)), d16(10));

      // Round half up: -7>>1 -> -3, 7>>1 -> 4
      start_test();
      beat(1, 1, 0, -7, 1, 0, 1);
      bubble(6);
      check_eq("t9_neg_rnd", d16(int'(res_data)), d16(-3));
      start_test();
      beat(1, 1, 0, 7, 1, 0, 1);
      bubble(6);
      check_eq("t9_pos_rnd", d16(int'(res_data)), d16(4));

      // Reset while a frame is in flight
      start_test();
      beat(1, 0, 0, 3, 3, 100, 0);
      beat(0, 0, 0, 4, 4, 0, 0);
      beat(0, 1, 0, 5, 5, 0, 0);
      check_eq("t10_busy_pre", 32'(bus.acc_busy), 32'd1);
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      #2;
      a_RST = 1'b1;
      #1;
      check_eq("t10_valid", 32'(bus.out_valid), 32'd0);
      check_eq("t10_data", d16(int'(bus.out_data)), 32'd0);
      check_eq("t10_busy", 32'(bus.acc_busy), 32'd0);
      bubble(2);
      a_RST = 1'b0;
      bubble(6);
      check_eq("t10_no_res", 32'(res_cnt), 32'd0);

      // acc restarts from 0 after reset, even without a first marker
      start_test();
      beat(0, 1, 0, 3, 3, 0, 0);
      bubble(6);
      check_eq("t11_count", 32'(res_cnt), 32'd1);
      check_eq("t11_data", d16(int'(res_data)), d16(9));
      start_test();
      beat(1, 1, 0, 4, 4, 0, 0);
      bubble(6);
      check_eq("t11_frame", d16(int'(res_data)), d16(16));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
